// File: rtl/scanline_tile_renderer.sv
// Renders one LCD scanline from background/window tile maps, one shaded pixel per cycle.
// Map and tile reads go through synchronous VRAM ports with one cycle of read latency.
module scanline_tile_renderer #(
  parameter int SCREEN_W   = 160,
  parameter int MAP_DIM    = 32,
  parameter int TILE_COUNT = 384,
  parameter int BPP        = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              drawline,
  input  logic [7:0]                        line,
  input  logic [7:0]                        scroll_x,
  input  logic [7:0]                        scroll_y,
  input  logic                              win_en,
  input  logic [7:0]                        win_x,
  input  logic [7:0]                        win_y,
  input  logic [(2**BPP)*BPP-1:0]           palette,
  output logic                              map_sel,
  output logic [2*$clog2(MAP_DIM)-1:0]      map_addr,
  input  logic [$clog2(TILE_COUNT)-1:0]     map_data,
  output logic [$clog2(TILE_COUNT)+2:0]     tile_addr,
  input  logic [8*BPP-1:0]                  tile_data,
  output logic                              pix_valid,
  output logic [7:0]                        pix_x,
  output logic [BPP-1:0]                    pix_shade,
  output logic                              busy,
  output logic                              render_complete
);

  localparam int TI = $clog2(TILE_COUNT);
  localparam int MB = $clog2(MAP_DIM);
  localparam int PW = (2**BPP)*BPP;
  localparam logic [7:0] CMASK  = 8'(MAP_DIM*8-1);
  localparam logic [8:0] MAPPIX = 9'(MAP_DIM*8);
  localparam logic [8:0] LASTX  = 9'(SCREEN_W-1);

  typedef enum logic [2:0] {IDLE, MAP_RD, TILE_RD, EMIT, DONE} state_t;

  state_t             state;
  logic [8:0]         x_q;
  logic [2:0]         col_q;
  logic [2:0]         trow_q;
  logic               win_act;
  logic               first_q;
  logic [8*BPP-1:0]   row_q;
  logic [TI+2:0]      tile_addr_q;
  logic [7:0]         line_q, sx_q, sy_q, wx_q, wy_q;
  logic               wen_q;
  logic [PW-1:0]      pal_q;

  logic [7:0]         s_line, s_sx, s_sy, s_wx, s_wy;
  logic               s_en;
  logic [8:0]         nx;
  logic               nact;
  logic [7:0]         nfx, nfy;
  logic [8*BPP-1:0]   cur_row;
  logic [BPP-1:0]     cur_idx;
  logic               fetch;

  function automatic logic win_cond(input logic [8:0] xv, input logic en,
                                    input logic [7:0] ln, input logic [7:0] wxo,
                                    input logic [7:0] wyo);
    logic [8:0] dy;
    dy = {1'b0, ln} - {1'b0, wyo};
    return en && (ln >= wyo) && (xv >= {1'b0, wxo}) && (dy < MAPPIX);
  endfunction

  // In IDLE the first fetch is computed from the live inputs, since they are latched on the same edge.
  always_comb begin
    s_line = (state == IDLE) ? line     : line_q;
    s_sx   = (state == IDLE) ? scroll_x : sx_q;
    s_sy   = (state == IDLE) ? scroll_y : sy_q;
    s_wx   = (state == IDLE) ? win_x    : wx_q;
    s_wy   = (state == IDLE) ? win_y    : wy_q;
    s_en   = (state == IDLE) ? win_en   : wen_q;
    nx     = (state == IDLE) ? 9'd0 : x_q + 9'd1;
    nact   = ((state != IDLE) && win_act) || win_cond(nx, s_en, s_line, s_wx, s_wy);
    if (nact) begin
      nfx = (nx[7:0] - s_wx) & CMASK;
      nfy = (s_line - s_wy) & CMASK;
    end else begin
      nfx = (nx[7:0] + s_sx) & CMASK;
      nfy = (s_line + s_sy) & CMASK;
    end
    cur_row = first_q ? tile_data : row_q;
    cur_idx = cur_row[col_q*BPP +: BPP];
    fetch   = (state == IDLE && drawline) ||
              (state == EMIT && x_q != LASTX && (col_q == 3'd7 || (nact && !win_act)));
  end

  // The tile row address must reach VRAM in the same cycle map_data arrives.
  assign tile_addr = (state == TILE_RD) ? {map_data, trow_q} : tile_addr_q;
  assign pix_x     = pix_valid ? x_q[7:0] : 8'd0;
  assign pix_shade = pix_valid ? pal_q[cur_idx*BPP +: BPP] : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      x_q             <= '0;
      col_q           <= '0;
      trow_q          <= '0;
      win_act         <= 1'b0;
      first_q         <= 1'b0;
      row_q           <= '0;
      tile_addr_q     <= '0;
      line_q          <= '0;
      sx_q            <= '0;
      sy_q            <= '0;
      wx_q            <= '0;
      wy_q            <= '0;
      wen_q           <= 1'b0;
      pal_q           <= '0;
      map_sel         <= 1'b0;
      map_addr        <= '0;
      pix_valid       <= 1'b0;
      busy            <= 1'b0;
      render_complete <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (drawline) begin
            state  <= MAP_RD;
            busy   <= 1'b1;
            x_q    <= '0;
            line_q <= line;
            sx_q   <= scroll_x;
            sy_q   <= scroll_y;
            wen_q  <= win_en;
            wx_q   <= win_x;
            wy_q   <= win_y;
            pal_q  <= palette;
          end
        end
        MAP_RD: state <= TILE_RD;
        TILE_RD: begin
          tile_addr_q <= tile_addr;
          state       <= EMIT;
          pix_valid   <= 1'b1;
          first_q     <= 1'b1;
        end
        EMIT: begin
          first_q <= 1'b0;
          row_q   <= cur_row;
          col_q   <= col_q + 3'd1;
          if (x_q == LASTX) begin
            state           <= DONE;
            pix_valid       <= 1'b0;
            busy            <= 1'b0;
            render_complete <= 1'b1;
          end else begin
            x_q <= x_q + 9'd1;
            if (fetch) begin
              state     <= MAP_RD;
              pix_valid <= 1'b0;
            end
          end
        end
        DONE: begin
          render_complete <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // Every new fetch recomputes window state and the map/tile coordinates for the next pixel.
      if (fetch) begin
        win_act  <= nact;
        map_sel  <= nact;
        map_addr <= {nfy[MB+2:3], nfx[MB+2:3]};
        col_q    <= nfx[2:0];
        trow_q   <= nfy[2:0];
      end
    end
  end

endmodule

// File: tb/tb_scanline_tile_renderer.sv
// Directed bench for scanline_tile_renderer with a VRAM model and a per-pixel reference.
module tb_scanline_tile_renderer;

  logic        clk = 1'b0;
  logic        reset;
  logic        drawline;
  logic [7:0]  line, scroll_x, scroll_y, win_x, win_y;
  logic        win_en;
  logic [7:0]  palette;
  logic        map_sel;
  logic [9:0]  map_addr;
  logic [8:0]  map_data;
  logic [11:0] tile_addr;
  logic [15:0] tile_data;
  logic        pix_valid;
  logic [7:0]  pix_x;
  logic [1:0]  pix_shade;
  logic        busy;
  logic        render_complete;

  int checks = 0;
  int errors = 0;
  bit all3 = 1'b0;
  int c_line, c_sx, c_sy, c_wx, c_wy;
  bit c_wen;
  logic [7:0] c_pal;

  scanline_tile_renderer dut (
    .clk(clk), .reset(reset), .drawline(drawline), .line(line),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .win_en(win_en),
    .win_x(win_x), .win_y(win_y), .palette(palette), .map_sel(map_sel),
    .map_addr(map_addr), .map_data(map_data), .tile_addr(tile_addr),
    .tile_data(tile_data), .pix_valid(pix_valid), .pix_x(pix_x),
    .pix_shade(pix_shade), .busy(busy), .render_complete(render_complete)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] bg_ent(input int r, input int c);
    return 9'((r*5 + c) % 256);
  endfunction

  function automatic logic [8:0] win_ent(input int r, input int c);
    return 9'(300 + (r*3 + c) % 80);
  endfunction

  function automatic logic [15:0] tile_row(input int t, input int r);
    logic [15:0] row;
    for (int p = 0; p < 8; p++)
      row[p*2 +: 2] = all3 ? 2'd3 : 2'((p + r*(t+1)) % 4);
    return row;
  endfunction

  // VRAM: both ports return data one cycle after the address is presented.
  always @(posedge clk) begin
    map_data  <= map_sel ? win_ent(int'(map_addr[9:5]), int'(map_addr[4:0]))
                         : bg_ent(int'(map_addr[9:5]), int'(map_addr[4:0]));
    tile_data <= tile_row(int'(tile_addr[11:3]), int'(tile_addr[2:0]));
  end

  function automatic logic [1:0] exp_shade(input int x);
    int fx, fy, ent, ci;
    logic [15:0] row;
    if (c_wen && c_line >= c_wy && x >= c_wx) begin
      fx  = x - c_wx;
      fy  = c_line - c_wy;
      ent = int'(win_ent(fy/8, (fx/8) % 32));
    end else begin
      fx  = (x + c_sx) % 256;
      fy  = (c_line + c_sy) % 256;
      ent = int'(bg_ent(fy/8, fx/8));
    end
    row = tile_row(ent, fy % 8);
    ci  = int'(row[2*(fx%8) +: 2]);
    return c_pal[2*ci +: 2];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input int ln, input int sx, input int sy, input bit wen,
                               input int wx, input int wy, input logic [7:0] pal, input bit a3);
    line     = 8'(ln);
    scroll_x = 8'(sx);
    scroll_y = 8'(sy);
    win_en   = wen;
    win_x    = 8'(wx);
    win_y    = 8'(wy);
    palette  = pal;
    all3     = a3;
  endtask

  task automatic runLine(input string name, input int exp_last, input int nlines,
                         input int reset_at, input int maddr1, input int taddr2,
                         input int split_cyc, input int split_taddr, input bit pal_change);
    int period, total, k, npix, exp_x, rc_cnt, last_pix, post_pix, bg_after;
    period   = exp_last + 2;
    total    = (reset_at > 0) ? 230 : nlines*period;
    k        = 0;
    npix     = 0;
    exp_x    = 0;
    rc_cnt   = 0;
    last_pix = -1;
    post_pix = 0;
    bg_after = 0;
    @(negedge clk);
    c_line = int'(line);
    c_sx   = int'(scroll_x);
    c_sy   = int'(scroll_y);
    c_wen  = win_en;
    c_wx   = int'(win_x);
    c_wy   = int'(win_y);
    c_pal  = palette;
    drawline = 1'b1;
    for (int cyc = 1; cyc <= total; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        checkOutput({name, "_busy_c1"}, 32'(busy), 32'd1);
        checkOutput({name, "_map_addr_c1"}, 32'(map_addr), 32'(maddr1));
        if (nlines == 1) drawline = 1'b0;
      end
      if (cyc == 2) checkOutput({name, "_tile_addr_c2"}, 32'(tile_addr), 32'(taddr2));
      if (split_cyc > 0 && cyc == split_cyc) begin
        checkOutput({name, "_split_sel"}, 32'(map_sel), 32'd1);
        checkOutput({name, "_split_map_addr"}, 32'(map_addr), 32'd0);
      end
      if (split_cyc > 0 && cyc == split_cyc + 1)
        checkOutput({name, "_split_tile_addr"}, 32'(tile_addr), 32'(split_taddr));
      if (split_cyc > 0 && cyc > split_cyc && busy && !map_sel) bg_after++;
      if (pix_valid) begin
        if (reset_at > 0 && cyc > reset_at) post_pix++;
        else begin
          if (npix == 0) checkOutput({name, "_first_pix_cyc"}, 32'(cyc), 32'(k*period + 3));
          checkOutput({name, "_pix_x"}, 32'(pix_x), 32'(exp_x));
          checkOutput({name, "_pix_shade"}, 32'(pix_shade), 32'(exp_shade(exp_x)));
          exp_x++;
          npix++;
          last_pix = cyc;
        end
      end
      if (render_complete) begin
        rc_cnt++;
        checkOutput({name, "_done_cyc"}, 32'(cyc), 32'(k*period + exp_last + 1));
        checkOutput({name, "_done_busy"}, 32'(busy), 32'd0);
        checkOutput({name, "_pix_count"}, 32'(npix), 32'd160);
        checkOutput({name, "_last_pix_cyc"}, 32'(last_pix), 32'(k*period + exp_last));
        k++;
        npix  = 0;
        exp_x = 0;
      end
      if (pal_change && cyc == 50) begin
        palette  = ~palette;
        scroll_x = scroll_x + 8'd3;
        line     = line + 8'd1;
      end
      if (reset_at > 0 && cyc == reset_at) reset = 1'b1;
      if (reset_at > 0 && cyc == reset_at + 1) begin
        checkOutput({name, "_rst_busy"}, 32'(busy), 32'd0);
        checkOutput({name, "_rst_pix_valid"}, 32'(pix_valid), 32'd0);
        reset = 1'b0;
      end
      if (cyc == total) drawline = 1'b0;
    end
    checkOutput({name, "_end_busy"}, 32'(busy), 32'd0);
    if (reset_at > 0) begin
      checkOutput({name, "_rst_no_done"}, 32'(rc_cnt), 32'd0);
      checkOutput({name, "_rst_no_pix"}, 32'(post_pix), 32'd0);
    end else begin
      checkOutput({name, "_done_count"}, 32'(rc_cnt), 32'(nlines));
    end
    if (split_cyc > 0) checkOutput({name, "_no_bg_after_split"}, 32'(bg_after), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    drawline = 1'b0;
    applyStimulus(0, 0, 0, 1'b0, 0, 0, 8'he4, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("reset_map_sel", 32'(map_sel), 32'd0);
    checkOutput("reset_map_addr", 32'(map_addr), 32'd0);
    checkOutput("reset_tile_addr", 32'(tile_addr), 32'd0);
    checkOutput("reset_pix_valid", 32'(pix_valid), 32'd0);
    checkOutput("reset_pix_x", 32'(pix_x), 32'd0);
    checkOutput("reset_pix_shade", 32'(pix_shade), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(render_complete), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    applyStimulus(0, 0, 0, 1'b0, 0, 0, 8'he4, 1'b0);
    runLine("aligned", 200, 1, 0, 0, 0, 0, 0, 1'b0);

    applyStimulus(0, 252, 0, 1'b0, 0, 0, 8'he4, 1'b0);
    runLine("wrap", 202, 1, 0, 31, 248, 0, 0, 1'b0);

    applyStimulus(10, 0, 250, 1'b0, 0, 0, 8'he4, 1'b0);
    runLine("scroll_y", 200, 1, 0, 0, 4, 0, 0, 1'b0);

    applyStimulus(5, 0, 0, 1'b1, 20, 0, 8'he4, 1'b0);
    runLine("window", 202, 1, 0, 0, 5, 27, 2405, 1'b0);

    applyStimulus(0, 0, 0, 1'b0, 0, 0, 8'h1b, 1'b1);
    runLine("palette", 200, 1, 0, 0, 0, 0, 0, 1'b1);

    applyStimulus(0, 0, 0, 1'b0, 0, 0, 8'he4, 1'b0);
    runLine("reset_mid", 200, 1, 50, 0, 0, 0, 0, 1'b0);
    runLine("after_reset", 200, 1, 0, 0, 0, 0, 0, 1'b0);

    runLine("held", 200, 3, 0, 0, 0, 0, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/scanline_tile_renderer.md
# scanline_tile_renderer

Parametrised single-scanline renderer for the whizgraphics video path. On each `drawline` request it walks one LCD line left to right, reads background and window tile-map entries and tile rows from VRAM read ports, applies scroll, window placement and the background palette, and streams one shaded pixel per cycle to the LCD line writer. When the line is finished it pulses `render_complete`. The block adds pixel-accurate scrolling with map wrap-around, a mid-line window split, and configurable screen width, map size, tile count and colour depth.

## Interface
- `SCREEN_W`, 160: pixels per line, 8..256.
- `MAP_DIM`, 32: tile map is MAP_DIM×MAP_DIM. Power of 2, MAP_DIM*8 ≤ 256.
- `TILE_COUNT`, 384: number of addressable tiles. TI = $clog2(TILE_COUNT).
- `BPP`, 2: bits per pixel colour index and per shade.
- `clk` in 1: the single clock. All logic is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `drawline` in 1: start request, sampled only in IDLE.
- `line` in 8: LCD line to render.
- `scroll_x`, `scroll_y` in 8 each: background scroll.
- `win_en` in 1, `win_x` in 8, `win_y` in 8: window enable and its top-left screen position. There is no −7 offset.
- `palette` in (2**BPP)*BPP: shade for colour index c is `palette[c*BPP +: BPP]`.
- `map_sel` out 1: 0 selects the background map, 1 selects the window map.
- `map_addr` out 2*$clog2(MAP_DIM): row*MAP_DIM + col.
- `map_data` in TI: tile index. Valid 1 cycle after the address.
- `tile_addr` out TI+3: tile_index*8 + row.
- `tile_data` in 8*BPP: one tile row. Pixel p is at `[p*BPP +: BPP]` and p=0 is leftmost. Valid 1 cycle after the address.
- `pix_valid` out 1, `pix_x` out 8, `pix_shade` out BPP: pixel stream.
- `busy` out 1: high in MAP_RD, TILE_RD and EMIT.
- `render_complete` out 1: one-cycle pulse.

## Operation
- States and transitions:
  - IDLE: goes to MAP_RD when `drawline`=1.
  - MAP_RD: goes to TILE_RD.
  - TILE_RD: goes to EMIT.
  - EMIT: goes to MAP_RD at a tile end or a window switch, or to DONE after pixel SCREEN_W−1.
  - DONE: goes to IDLE.
- On leaving IDLE, latch `line`, `scroll_*`, `win_*` and `palette`. Later input changes have no effect on the line in progress.
- Window is active for column x when `win_en` is set, `line` ≥ `win_y` and x ≥ `win_x`. Once active, it stays active to the end of the line.
- Background fetch coordinates:
  - bx = (x+scroll_x) mod MAP_DIM*8.
  - by = (line+scroll_y) mod MAP_DIM*8.
- Window fetch coordinates: wx = x−win_x, wy = line−win_y.
  - If wy ≥ MAP_DIM*8, the window is treated as inactive.
- MAP_RD drives `map_sel`, map_addr = (y>>3)*MAP_DIM + (x>>3).
- TILE_RD latches `map_data` and drives tile_addr = index*8 + (y&7).
- EMIT latches `tile_data` in its first cycle. It then emits pixels from column (x&7) of the row, one per cycle. It stops at row column 7, at SCREEN_W, or when the next x first satisfies the window condition.
- Each emitted pixel: `pix_valid`=1, `pix_x`=x, `pix_shade`=palette shade of the colour index; then x increments.
- `drawline` outside IDLE is ignored. It is not queued.
- `reset` during any state returns the block to IDLE next cycle, with no `render_complete` and no further pixels.
- Reset values: all outputs 0, including `map_sel`, `map_addr`, `tile_addr`, `pix_*`, `busy` and `render_complete`.

## Timing
- `drawline` sampled high at cycle 0 → MAP_RD at cycle 1, with `busy`=1 from cycle 1.
- First `pix_valid` at cycle 3.
- Per fetch: 2 overhead cycles + n pixel cycles, where n ≤ 8.
- Aligned line (scroll_x%8=0, no window, SCREEN_W=160):
  - Pixels of tile k appear at cycles 10k+3 .. 10k+10.
  - Last pixel at cycle 200.
  - DONE at cycle 201: `render_complete`=1 and `busy`=0.
  - IDLE at cycle 202, where a new `drawline` is accepted.
- General line: total cycles from MAP_RD to the last pixel = 2×fetches + SCREEN_W.
- `pix_x` is strictly increasing within a line, and exactly SCREEN_W pixels are emitted per line.
- While in EMIT, `map_addr`/`tile_addr` hold their last values.

## Test plan
- Aligned line: scroll 0, win_en=0, line=0, map entry (c,0)=c, tile c row 0 = colour pattern 0,1,2,3,0,1,2,3, palette 8'he4 → pixels x=0..159 have shade x%4. `render_complete` at cycle 201, 160 pixels total.
- Wrap and fine scroll: scroll_x=252, line=0 → first fetch map col 31 emits 4 pixels, then col 0. Last pixel at cycle 2×21+160 = 202. scroll_y=250, line=10 → map row 0, tile row 4.
- Window split: win_en=1, win_x=20, win_y=0, line=5:
  - background tile 2 stops after x=19.
  - x=20 comes from window map entry (0,0), tile row 5, with `map_sel`=1.
  - No background fetches after that point.
- Palette: palette 8'h1b with colour index 3 everywhere → every shade is 0. Changing `palette` mid-line has no effect on the line in progress.
- Reset mid-line: assert `reset` at cycle 50 → cycle 51 has busy=0 and pix_valid=0, and `render_complete` never fires. A new `drawline` renders a full line correctly.
- `drawline` held high continuously → back-to-back lines start at cycles 0, 202, 404…. Each line emits exactly 160 pixels and one `render_complete`.
